// File: rtl/display_scan_ctrl.sv
// Time-multiplexed BCD digit scanner: one shared decoder code (E) plus active-low digit strobes (AN).
// Latency: E/AN/FRAME are registered; a wrap tick shows the freshly sampled D on the same edge.
// Backpressure: none; EN=0 freezes the scan position and blanks the display on the next edge.
module display_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 16
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                EN,
    input  logic                BLANK_LZ,
    input  logic [4*DIGITS-1:0] D,
    output logic [3:0]          E,
    output logic [DIGITS-1:0]   AN,
    output logic                FRAME
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int GW = $clog2(GUARD + 2);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [GW-1:0]       guard_q, guard_d;
    logic                live_q, live_d;
    logic [3:0]          e_q, e_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                wrap;
    logic [IW-1:0]       idx_nxt;
    logic [4*DIGITS-1:0] snap_nxt;
    logic [3:0]          digit_nxt;
    logic                lz_blank;
    logic                upper_zero;
    logic [DIGITS-1:0]   an_nxt;
    logic [DIGITS-1:0]   an_cur;

    assign tick = EN && (presc_q == PW'(DIV - 1));

    // Work out which digit/snapshot the next tick lands on and what E and AN should show for it.
    always_comb begin
        wrap       = (idx_q == IW'(DIGITS - 1));
        idx_nxt    = wrap ? '0 : idx_q + 1'b1;
        snap_nxt   = wrap ? D : snap_q;
        digit_nxt  = 4'hF;
        lz_blank   = 1'b0;
        upper_zero = 1'b1;
        an_nxt     = '1;
        an_cur     = '1;
        // Walk from the most significant digit down so upper_zero covers digits DIGITS-1..i.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (snap_nxt[4*i +: 4] == 4'd0);
            if (idx_nxt == IW'(i)) begin
                digit_nxt = snap_nxt[4*i +: 4];
                lz_blank  = BLANK_LZ && (i != 0) && upper_zero;
                an_nxt[i] = 1'b0;
            end
            if (idx_q == IW'(i)) begin
                an_cur[i] = 1'b0;
            end
        end
    end

    // Next-state: prescaler/slot advance, snapshot on wrap, guard countdown before enabling a digit.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        guard_d = guard_q;
        live_d  = live_q;
        e_d     = e_q;
        an_d    = an_q;
        frame_d = 1'b0;
        if (!EN) begin
            // Position is held; live is dropped so a resume waits for a fresh tick before lighting.
            e_d    = 4'hF;
            an_d   = '1;
            live_d = 1'b0;
        end else if (tick) begin
            presc_d = '0;
            idx_d   = idx_nxt;
            snap_d  = snap_nxt;
            frame_d = wrap;
            live_d  = 1'b1;
            e_d     = lz_blank ? 4'hF : digit_nxt;
            guard_d = GW'(GUARD);
            an_d    = (GUARD == 0) ? an_nxt : '1;
        end else begin
            presc_d = presc_q + 1'b1;
            if (guard_q > GW'(1)) begin
                guard_d = guard_q - 1'b1;
            end else if (guard_q == GW'(1)) begin
                guard_d = '0;
                if (live_q) begin
                    an_d = an_cur;
                end
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
            idx_q   <= IW'(DIGITS - 1);
            snap_q  <= '0;
            guard_q <= '0;
            live_q  <= 1'b0;
            e_q     <= 4'hF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            guard_q <= guard_d;
            live_q  <= live_d;
            e_q     <= e_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign E     = e_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares a single BCD-to-7-segment decoder (4-bit input E, active-low segments, value >9 shows blank) among DIGITS BCD digit sources.
- Latches a coherent snapshot of all digits once per frame and steps through them at a fixed refresh rate.
- Drives the shared decoder input and an active-low digit-enable bus, with optional leading-zero blanking and an anti-ghosting guard interval.
- Sits between the adder's BCD result registers and the display decoder/board digit strobes.

Parameters:
- DIGITS, 4, number of BCD digits scanned (2..8).
- DIV, 50000, CLOCK_50 cycles per digit slot (≥2).
- GUARD, 16, cycles at the start of each slot with all digits disabled (0 ≤ GUARD < DIV).

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  scan enable; low freezes the scan and blanks the display.
- BLANK_LZ  in  1  1 = suppress leading zeros.
- D  in  4*DIGITS  packed BCD digits; D[3:0] = digit 0 (least significant).
- E  out  4  code to the shared decoder; 4'hF = blank.
- AN  out  DIGITS  active-low digit enables; at most one bit low.
- FRAME  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async, RESET=1): prescaler=0, idx=DIGITS-1, snapshot=0, E=4'hF, AN=all ones, FRAME=0, guard counter=0. All outputs are registered.
- Prescaler counts 0..DIV-1 while EN=1. Tick = prescaler at DIV-1 with EN=1. The prescaler wraps to 0 on tick. EN=0 holds the prescaler and idx.
- On tick with idx=DIGITS-1:
  - idx←0.
  - snapshot←D as sampled that edge.
  - FRAME=1 for that cycle.
- On tick with any other idx: idx←idx+1. Snapshot is unchanged.
- The first tick after reset therefore starts frame 0 at digit 0 with a fresh snapshot.
- E update: E is updated on the tick edge from the new idx and the new snapshot. On a wrap tick, the new snapshot is D itself, with no extra cycle of latency.
- Leading-zero blanking: digit i is blanked (E=4'hF) if BLANK_LZ=1, i≠0, and snapshot digits DIGITS-1 down to i are all 0. Digit 0 is never blanked by this rule.
- Non-BCD digit values (10..15) pass through unchanged; the decoder shows them as blank.
- Guard interval: AN=all ones for GUARD cycles starting at the tick edge. After that, AN[idx]=0 and the other bits stay 1 until the next tick. With GUARD=0, AN[idx] goes low on the tick edge.
- EN=0:
  - On the next edge: AN=all ones, E=4'hF, FRAME=0.
  - Prescaler, idx, guard counter and snapshot hold their values.
- EN re-asserted: the scan resumes from the held prescaler/idx state. AN stays all ones until the next tick, which restarts the guard.
- Changes on D between wrap ticks have no effect on E (tear-free frames).
- RESET mid-frame: immediate return to the reset values, independent of the clock.
- Scan rate per digit = f(CLOCK_50)/DIV; frame period = DIGITS*DIV cycles.

Test Plan:
- DIGITS=4, DIV=4, GUARD=1; release RESET with EN=1, D=16'h1234:
  - FRAME pulses at cycle 4.
  - The E sequence per tick is 4,3,2,1.
  - AN goes 1110, 1101, 1011, 0111, each after one all-ones guard cycle.
- Reset values: assert RESET asynchronously mid-slot → AN=1111, E=F, FRAME=0 before the next clock edge. Releasing RESET restarts at digit 0 after 4 cycles.
- Snapshot: D=16'h0042. Change D to 16'h9999 while idx=1. E keeps showing 0,0 for digits 2 and 3 until the next FRAME, then 9,9,9,9.
- Leading-zero blanking:
  - BLANK_LZ=1, D=16'h0040 → E per digit 0..3 = 0,4,F,F.
  - D=16'h0000 → 0,F,F,F.
  - BLANK_LZ=0 → 0,0,0,0.
- EN control: deassert EN mid-slot → AN=1111, E=F the next cycle and idx frozen. Reassert → no digit enabled until the next tick, then the scan continues with the following digit.
- Non-BCD value: D=16'h00A5, BLANK_LZ=1 → E per digit = 5,A,F,F. AN never has more than one low bit in any cycle (assertion).
